// File: rtl/atm_controller.sv
// atm_controller: clocked ATM transaction engine with an on-chip bank of account balances.
//
// On reset, every account is loaded with INIT_BAL, one account per cycle. After that,
// requests are accepted one at a time. Each request is exit, balance inquiry, withdraw or
// transfer. A transfer writes both accounts on the same clock edge.
//
// Ports:
//   clk              rising-edge system clock
//   rst              synchronous, active-high reset; aborts any request and re-runs init
//   start            request strobe, sampled only while busy is low
//   Select           0 exit, 1 balance inquiry, 2 withdraw, 3 transfer
//   AccountNumber_s  source account
//   AccountNumber_d  destination account (transfer only)
//   Amount           withdraw/transfer amount
//   busy             high during init and while a request is in flight
//   done             one-cycle completion pulse
//   Balance          source balance after the operation, held until the next done
//   result           0 OK, 1 insufficient funds, 2 rejected, 3 exit; valid with done
//
// Optional build macro: ATM_TXN_LIMIT_EN. When it is defined, a withdraw or transfer whose
// Amount is greater than TXN_LIMIT is rejected with result 2.

module atm_controller #(
    parameter int unsigned ACCT_W    = 4,
    parameter int unsigned BAL_W     = 10,
    parameter int unsigned INIT_BAL  = 100,
    parameter int unsigned TXN_LIMIT = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        Select,
    input  logic [ACCT_W-1:0] AccountNumber_s,
    input  logic [ACCT_W-1:0] AccountNumber_d,
    input  logic [BAL_W-1:0]  Amount,
    output logic              busy,
    output logic              done,
    output logic [BAL_W-1:0]  Balance,
    output logic [1:0]        result
);

    localparam int unsigned NACCT = 2 ** ACCT_W;

    localparam logic [1:0] SelExit  = 2'd0;
    localparam logic [1:0] SelInq   = 2'd1;
    localparam logic [1:0] SelWd    = 2'd2;
    localparam logic [1:0] SelXfer  = 2'd3;

    localparam logic [1:0] ResOk    = 2'd0;
    localparam logic [1:0] ResFunds = 2'd1;
    localparam logic [1:0] ResRej   = 2'd2;
    localparam logic [1:0] ResExit  = 2'd3;

    typedef enum logic [2:0] {StInit, StIdle, StLoad, StExec, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [ACCT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [ACCT_W-1:0]   src_idx_q, src_idx_d;
    logic [ACCT_W-1:0]   dst_idx_q, dst_idx_d;
    logic [BAL_W-1:0]    amt_q, amt_d;
    logic [BAL_W-1:0]    src_bal_q, src_bal_d;
    logic [BAL_W-1:0]    dst_bal_q, dst_bal_d;
    logic [1:0]          res_q, res_d;
    logic [BAL_W-1:0]    new_src_q, new_src_d;
    logic [BAL_W-1:0]    new_dst_q, new_dst_d;
    logic [BAL_W-1:0]    balance_q, balance_d;
    logic [1:0]          result_q, result_d;

    logic [BAL_W-1:0]    acct_q [NACCT];

    logic [BAL_W-1:0]    diff;
    logic [BAL_W:0]      sum;
    logic                short_funds;
    logic                over_limit;
    logic                wr_src;
    logic                wr_dst;

    // Balance arithmetic works on the latched request and the loaded balances.
    assign diff        = src_bal_q - amt_q;
    assign sum         = {1'b0, dst_bal_q} + {1'b0, amt_q};
    assign short_funds = amt_q > src_bal_q;

`ifdef ATM_TXN_LIMIT_EN
    assign over_limit  = 32'(amt_q) > TXN_LIMIT;
`else
    assign over_limit  = 1'b0;
`endif

    // Only successful withdraws and transfers change the bank.
    assign wr_src = (state_q == StWrite) && (res_q == ResOk) && sel_q[1];
    assign wr_dst = (state_q == StWrite) && (res_q == ResOk) && (sel_q == SelXfer);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        src_idx_d = src_idx_q;
        dst_idx_d = dst_idx_q;
        amt_d     = amt_q;
        src_bal_d = src_bal_q;
        dst_bal_d = dst_bal_q;
        res_d     = res_q;
        new_src_d = new_src_q;
        new_dst_d = new_dst_q;
        balance_d = balance_q;
        result_d  = result_q;

        case (state_q)
            StInit: begin
                cnt_d = cnt_q + ACCT_W'(1);
                if (cnt_q == ACCT_W'(NACCT - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (start) begin
                    sel_d     = Select;
                    src_idx_d = AccountNumber_s;
                    dst_idx_d = AccountNumber_d;
                    amt_d     = Amount;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                src_bal_d = acct_q[src_idx_q];
                dst_bal_d = acct_q[dst_idx_q];
                state_d   = StExec;
            end
            StExec: begin
                // Rejected operations report the pre-op source balance.
                new_src_d = src_bal_q;
                new_dst_d = dst_bal_q;
                case (sel_q)
                    SelExit: begin
                        res_d     = ResExit;
                        new_src_d = '0;
                    end
                    SelInq: begin
                        res_d = ResOk;
                    end
                    SelWd: begin
                        if (over_limit) begin
                            res_d = ResRej;
                        end else if (short_funds) begin
                            res_d = ResFunds;
                        end else begin
                            res_d     = ResOk;
                            new_src_d = diff;
                        end
                    end
                    SelXfer: begin
                        if (src_idx_q == dst_idx_q) begin
                            res_d = ResRej;
                        end else if (over_limit) begin
                            res_d = ResRej;
                        end else if (short_funds) begin
                            res_d = ResFunds;
                        end else if (sum[BAL_W]) begin
                            res_d = ResRej;
                        end else begin
                            res_d     = ResOk;
                            new_src_d = diff;
                            new_dst_d = sum[BAL_W-1:0];
                        end
                    end
                endcase
                state_d = StWrite;
            end
            StWrite: begin
                balance_d = new_src_q;
                result_d  = res_q;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            sel_q     <= '0;
            src_idx_q <= '0;
            dst_idx_q <= '0;
            amt_q     <= '0;
            src_bal_q <= '0;
            dst_bal_q <= '0;
            res_q     <= '0;
            new_src_q <= '0;
            new_dst_q <= '0;
            balance_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            src_idx_q <= src_idx_d;
            dst_idx_q <= dst_idx_d;
            amt_q     <= amt_d;
            src_bal_q <= src_bal_d;
            dst_bal_q <= dst_bal_d;
            res_q     <= res_d;
            new_src_q <= new_src_d;
            new_dst_q <= new_dst_d;
            balance_q <= balance_d;
            result_q  <= result_d;
        end
    end

    // Account bank: not reset directly; INIT rewrites every entry after reset.
    // Source and destination never alias on a write because s==d transfers are rejected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                acct_q[cnt_q] <= BAL_W'(INIT_BAL);
            end
            if (wr_src) begin
                acct_q[src_idx_q] <= new_src_q;
            end
            if (wr_dst) begin
                acct_q[dst_idx_q] <= new_dst_q;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign Balance = balance_q;
    assign result  = result_q;

endmodule

// File: tb/tb_atm_controller.sv
// Self-checking bench for atm_controller. It holds a behavioural model of the account bank,
// applies directed and random requests, and uses one compare process that checks busy, done,
// Balance and result every cycle.

module tb_atm_controller;

    localparam int NACCT    = 16;
    localparam int INIT_BAL = 100;
    localparam int LIMIT    = 500;
    localparam int BMAX     = 1023;
`ifdef ATM_TXN_LIMIT_EN
    localparam bit LimOn = 1'b1;
`else
    localparam bit LimOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel_in = '0;
    logic [3:0] acct_s = '0;
    logic [3:0] acct_d = '0;
    logic [9:0] amount = '0;
    logic       busy;
    logic       done;
    logic [9:0] balance;
    logic [1:0] result;

    always #5 clk = ~clk;

    atm_controller dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .Select          (sel_in),
        .AccountNumber_s (acct_s),
        .AccountNumber_d (acct_d),
        .Amount          (amount),
        .busy            (busy),
        .done            (done),
        .Balance         (balance),
        .result          (result)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;          // rising edges seen so far
    int init_end = 0;   // first edge count at which init is over
    bit pend = 1'b0;
    int pend_n = 0;
    int pend_bal = 0;
    int pend_res = 0;
    int last_bal = 0;
    int last_res = 0;
    int bal [NACCT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bank model: applies one request and returns the expected result and Balance.
    function automatic void model(input int sel, input int s, input int d, input int amt,
                                  output int res, output int bout);
        res = 0;
        case (sel)
            0: res = 3;
            1: res = 0;
            2: begin
                if (LimOn && amt > LIMIT)  res = 2;
                else if (amt > bal[s])     res = 1;
                else                       bal[s] = bal[s] - amt;
            end
            default: begin
                if (s == d)                       res = 2;
                else if (LimOn && amt > LIMIT)    res = 2;
                else if (amt > bal[s])            res = 1;
                else if (bal[d] + amt > BMAX)     res = 2;
                else begin
                    bal[s] = bal[s] - amt;
                    bal[d] = bal[d] + amt;
                end
            end
        endcase
        bout = (sel == 0) ? 0 : bal[s];
    endfunction

    // Compare process: every cycle, 1 time unit after the rising edge.
    always @(posedge clk) begin
        int exp_busy;
        int exp_done;
        #1;
        n++;
        if (rst) begin
            chk("reset_busy", busy, 1);
            chk("reset_done", done, 0);
            chk("reset_balance", balance, 0);
            chk("reset_result", result, 0);
            pend = 1'b0;
            last_bal = 0;
            last_res = 0;
        end else begin
            exp_busy = ((n < init_end) || pend) ? 1 : 0;
            exp_done = (pend && n == pend_n) ? 1 : 0;
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            if (exp_done != 0) begin
                last_bal = pend_bal;
                last_res = pend_res;
                pend = 1'b0;
            end
            chk("balance", balance, last_bal);
            chk("result", result, last_res);
        end
    end

    // Called on a falling edge; holds rst for 'cycles' edges and measures the init window.
    task automatic do_reset(input int cycles);
        int cnt;
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        init_end = n + NACCT;
        foreach (bal[i]) bal[i] = INIT_BAL;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("init_busy_cycles", cnt, NACCT);
    endtask

    task automatic do_req(input int sel, input int s, input int d, input int amt,
                          output int rb, output int rr);
        int w;
        int r;
        int b;
        @(negedge clk);
        w = 0;
        while (busy !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        rb = -1;
        rr = -1;
        if (busy !== 1'b0) begin
            chk("idle_wait", busy, 0);
            return;
        end
        model(sel, s, d, amt, r, b);
        sel_in   = 2'(sel);
        acct_s   = 4'(s);
        acct_d   = 4'(d);
        amount   = 10'(amt);
        start    = 1'b1;
        pend_bal = b;
        pend_res = r;
        pend_n   = n + 4;
        pend     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        // Scramble the inputs; the latched request must be unaffected.
        sel_in = 2'($urandom);
        acct_s = 4'($urandom);
        acct_d = 4'($urandom);
        amount = 10'($urandom);
        w = 0;
        while (pend && w < 12) begin
            @(negedge clk);
            w++;
        end
        if (pend) begin
            chk("done_timeout", 0, 1);
            pend = 1'b0;
        end
        rb = int'(balance);
        rr = int'(result);
    endtask

    initial begin
        int b;
        int r;
        int s;
        int d;
        int amt;
        int srcs [8] = '{0, 2, 3, 4, 6, 7, 8, 10};

        @(negedge clk);
        @(negedge clk);
        do_reset(1);

        for (int a = 0; a < NACCT; a++) begin
            do_req(1, a, 0, 0, b, r);
            chk("init_inq_bal", b, 100);
            chk("init_inq_res", r, 0);
        end

        do_req(2, 5, 0, 30, b, r);
        chk("wd30_bal", b, 70);
        chk("wd30_res", r, 0);
        do_req(1, 5, 0, 0, b, r);
        chk("inq5_bal", b, 70);

        do_req(2, 2, 0, 101, b, r);
        chk("wd101_bal", b, 100);
        chk("wd101_res", r, 1);
        do_req(1, 2, 0, 0, b, r);
        chk("inq2_bal", b, 100);

        do_req(3, 1, 9, 40, b, r);
        chk("xfer40_bal", b, 60);
        chk("xfer40_res", r, 0);
        do_req(1, 9, 0, 0, b, r);
        chk("inq9_bal", b, 140);

        do_req(3, 3, 3, 1, b, r);
        chk("xfer_self_bal", b, 100);
        chk("xfer_self_res", r, 2);

        foreach (srcs[i]) begin
            do_req(3, srcs[i], 9, 100, b, r);
            chk("raise_res", r, 0);
        end
        do_req(3, 11, 9, 60, b, r);
        chk("raise60_bal", b, 40);
        do_req(1, 9, 0, 0, b, r);
        chk("inq9_1000", b, 1000);

        do_req(3, 12, 9, 30, b, r);
        chk("ovf_bal", b, 100);
        chk("ovf_res", r, 2);
        do_req(1, 9, 0, 0, b, r);
        chk("ovf_dst_kept", b, 1000);
        do_req(1, 12, 0, 0, b, r);
        chk("ovf_src_kept", b, 100);

        do_req(0, 4, 5, 7, b, r);
        chk("exit_bal", b, 0);
        chk("exit_res", r, 3);

        do_req(2, 13, 0, 0, b, r);
        chk("wd0_bal", b, 100);
        chk("wd0_res", r, 0);
        do_req(2, 14, 0, 100, b, r);
        chk("wd_all_bal", b, 0);
        chk("wd_all_res", r, 0);

        for (int i = 0; i < 150; i++) begin
            s = $urandom_range(0, NACCT - 1);
            d = ($urandom_range(0, 4) == 0) ? s : $urandom_range(0, NACCT - 1);
            case ($urandom_range(0, 3))
                0:       amt = $urandom_range(0, 50);
                1:       amt = $urandom_range(0, 150);
                2:       amt = $urandom_range(0, BMAX);
                default: amt = bal[s];
            endcase
            do_req($urandom_range(0, 3), s, d, amt, b, r);
        end

        // Reset two edges after a withdraw is latched: no done, full re-init.
        @(negedge clk);
        while (busy !== 1'b0) @(negedge clk);
        sel_in = 2'd2;
        acct_s = 4'd4;
        amount = 10'd10;
        start  = 1'b1;
        pend_n = n + 1000;
        pend   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        do_reset(3);
        for (int a = 0; a < NACCT; a++) begin
            do_req(1, a, 0, 0, b, r);
            chk("reinit_inq_bal", b, 100);
        end

        do_req(2, 6, 0, 501, b, r);
        chk("wd501_bal", b, 100);
`ifdef ATM_TXN_LIMIT_EN
        chk("wd501_res", r, 2);
`else
        chk("wd501_res", r, 1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
